// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen
//   640x480 @ 60 Hz VGA raster timing generator running from the 100 MHz
//   board clock. A 2-bit divider produces a 25 MHz pixel strobe; the pixel
//   and line counters advance on strobe cycles. Sync/active flags are
//   decoded from the next counter values and registered together with the
//   counters so that all coordinate-related outputs describe the same pixel.
//
// Ports
//   i_clk        : 100 MHz system clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   o_pix_stb    : one-cycle pixel enable every 4 clocks (25 MHz)
//   o_x, o_y     : horizontal / vertical counters (10-bit)
//   o_active     : visible-area flag
//   o_hs, o_vs   : horizontal / vertical sync, active low
//   o_animate    : pulse on the strobe cycle of the last visible pixel
//   o_frame_tick : pulse on the strobe cycle of the last pixel of the frame
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_pix_stb,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_active,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_animate,
  output logic       o_frame_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All counter comparisons are done on 10-bit unsigned values.
  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_param_check
    $error("vga_timing_gen: timing parameter sums must stay below 1024");
  end

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_ACT_M1 = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);

  logic [1:0] div_q, div_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       active_q, active_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       stb;

  assign stb = (div_q == 2'd3);

  always_comb begin
    div_d = div_q + 2'd1;
    x_d   = x_q;
    y_d   = y_q;
    if (stb) begin
      if (x_q == H_LAST) begin
        x_d = 10'd0;
        y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Decode from the next coordinates so flags line up with o_x/o_y.
    active_d = (x_d < H_ACT) && (y_d < V_ACT);
    hs_d     = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vs_d     = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q    <= 2'd0;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      active_q <= 1'b1;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      div_q    <= div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  // Pulses are pure decodes of registered state; div_q resets to 0 so all
  // three are low while reset is held.
  assign o_pix_stb    = stb;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_active     = active_q;
  assign o_hs         = hs_q;
  assign o_vs         = vs_q;
  assign o_animate    = stb && (x_q == H_ACT_M1) && (y_q == V_ACT_M1);
  assign o_frame_tick = stb && (x_q == H_LAST) && (y_q == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

  // Reduced raster for the second instance so whole frames fit in the run.
  localparam int SH_A = 16, SH_FP = 4, SH_S = 6, SH_BP = 4;
  localparam int SV_A = 10, SV_FP = 2, SV_S = 2, SV_BP = 3;
  localparam int S_FRAME_CLK = (SH_A + SH_FP + SH_S + SH_BP) * (SV_A + SV_FP + SV_S + SV_BP) * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_stb, a_act, a_hs, a_vs, a_anim, a_ft;
  logic [9:0] a_x, a_y;
  logic       b_stb, b_act, b_hs, b_vs, b_anim, b_ft;
  logic [9:0] b_x, b_y;

  vga_timing_gen u_dut_full (
    .i_clk(clk), .i_rst_n(rst_n), .o_pix_stb(a_stb), .o_x(a_x), .o_y(a_y),
    .o_active(a_act), .o_hs(a_hs), .o_vs(a_vs), .o_animate(a_anim), .o_frame_tick(a_ft)
  );

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
  ) u_dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .o_pix_stb(b_stb), .o_x(b_x), .o_y(b_y),
    .o_active(b_act), .o_hs(b_hs), .o_vs(b_vs), .o_animate(b_anim), .o_frame_tick(b_ft)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  longint      n = 0;          // rising edges since reset release
  longint      last_tick_n = -1;
  int          tick_cnt = 0;
  int          anim_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, n);
    end
  endtask

  // Reference: position follows directly from elapsed edges. Every 4th edge
  // moves one pixel, pixels run through a row-major raster of ht x vt.
  task automatic check_inst(input string nm, input int ha, input int hfp, input int hsw, input int hbp,
                            input int va, input int vfp, input int vsw, input int vbp,
                            input logic stb, input logic [9:0] x, input logic [9:0] y,
                            input logic act, input logic hs, input logic vs,
                            input logic anim, input logic ft, input bit in_rst);
    int ht, vt, ex, ey;
    longint p;
    bit es;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (in_rst) begin
      es = 0; ex = 0; ey = 0;
    end else begin
      es = ((n % 4) == 3);
      p  = n / 4;
      ex = int'(p % ht);
      ey = int'((p / ht) % vt);
    end
    chk({nm, ".stb"},    32'(stb),  32'(es));
    chk({nm, ".x"},      32'(x),    32'(ex));
    chk({nm, ".y"},      32'(y),    32'(ey));
    chk({nm, ".active"}, 32'(act),  32'(ex < ha && ey < va));
    chk({nm, ".hs"},     32'(hs),   32'(!(ex >= ha + hfp && ex < ha + hfp + hsw)));
    chk({nm, ".vs"},     32'(vs),   32'(!(ey >= va + vfp && ey < va + vfp + vsw)));
    chk({nm, ".animate"},32'(anim), 32'(es && ex == ha - 1 && ey == va - 1));
    chk({nm, ".ftick"},  32'(ft),   32'(es && ex == ht - 1 && ey == vt - 1));
  endtask

  task automatic check_all(input bit in_rst);
    check_inst("full", 640, 16, 96, 48, 480, 10, 2, 33,
               a_stb, a_x, a_y, a_act, a_hs, a_vs, a_anim, a_ft, in_rst);
    check_inst("small", SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP,
               b_stb, b_x, b_y, b_act, b_hs, b_vs, b_anim, b_ft, in_rst);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      check_all(0);
      if (b_anim) anim_cnt++;
      if (b_ft) begin
        tick_cnt++;
        if (last_tick_n >= 0) chk("small.tick_gap", 32'(n - last_tick_n), 32'(S_FRAME_CLK));
        last_tick_n = n;
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    last_tick_n = -1;
    tick_cnt = 0;
    anim_cnt = 0;
    #1;
    check_all(0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_all(1);
    end
    release_reset();

    // Two full-size lines plus three small frames.
    run(7000);
    chk("small.frame_ticks", 32'(tick_cnt), 32'((7000 + 1) / S_FRAME_CLK));
    chk("small.animates",    32'(anim_cnt), 32'(3));

    // Random mid-run asynchronous resets between clock edges.
    for (int r = 0; r < 4; r++) begin
      run(int'($urandom_range(300, 4000)));
      @(negedge clk);
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      check_all(1);
      repeat ($urandom_range(1, 5)) begin
        @(negedge clk);
        check_all(1);
      end
      release_reset();
    end
    run(2100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz board clock. It is the driver side of the pixel-coordinate interface consumed by the sprite and ROM blocks. It derives a 25 MHz pixel strobe and produces the horizontal and vertical counters (xx/yy), the active-video flag, and negative-polarity sync outputs for the Basys 3 VGA port. It also emits per-frame pulses that game logic uses to step animation once per frame.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- i_clk  in  1  100 MHz system clock; all logic on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- o_pix_stb  out  1  one-i_clk pulse every 4 cycles (25 MHz pixel enable)
- o_x  out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL=800)
- o_y  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL=525)
- o_active  out  1  1 when o_x<H_ACTIVE and o_y<V_ACTIVE
- o_hs  out  1  horizontal sync, active low
- o_vs  out  1  vertical sync, active low
- o_animate  out  1  one-cycle pulse at end of last active pixel of frame
- o_frame_tick  out  1  one-cycle pulse at last pixel of full frame

## Operation
- Pixel divider: a 2-bit counter div, reset to 0, increments every i_clk and wraps 3->0. o_pix_stb=1 exactly while div==3.
- Counters advance only on edges where div==3. On those edges o_x increments. If o_x==799, o_x becomes 0 and o_y increments. If o_y==524 as well, o_y becomes 0.
- Sync decode uses the next counter values and is registered alongside them, so o_x/o_y/o_active/o_hs/o_vs always describe the same pixel:
  - o_hs=0 iff 656<=o_x<=751 (H_ACTIVE+H_FP .. H_ACTIVE+H_FP+H_SYNC-1).
  - o_vs=0 iff 490<=o_y<=491.
  - o_active per its definition above.
- o_animate=1 for the single i_clk cycle where o_pix_stb=1 and o_x==639 and o_y==479. Otherwise 0.
- o_frame_tick=1 for the single i_clk cycle where o_pix_stb=1 and o_x==799 and o_y==524. Otherwise 0.
- Width rules: all comparisons are unsigned 10-bit. Parameter sums must stay below 1024; this is enforced by an elaboration-time check.
- No enable input; timing free-runs whenever i_rst_n=1.

## Timing
- Reset values (asynchronous, while i_rst_n=0):
  - div=0, o_x=0, o_y=0
  - o_active=1, o_hs=1, o_vs=1
  - o_pix_stb=0, o_animate=0, o_frame_tick=0
- After release, the first o_pix_stb is at the 4th rising edge: div goes 0,1,2,3.
- Each (o_x,o_y) value is held for exactly 4 i_clk cycles. o_pix_stb is high in the last of those 4 cycles. Consumers sample on i_clk while o_pix_stb=1.
- Line period is 3200 i_clk; frame period is 1,680,000 i_clk.
- o_hs low for 96 pixels = 384 i_clk per line. o_vs low for 2 lines = 6400 i_clk per frame.
- Output latency: o_x/o_y/sync/active change on the edge following the o_pix_stb cycle. No combinational path from any input to any output.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). Counting restarts from (0,0) with the full 4-cycle divider phase.
- Simultaneous wrap at (799,524): o_x and o_y wrap to 0 on the same edge, and o_frame_tick is asserted in the preceding stb cycle.

## Test plan
- Reset: hold i_rst_n=0 for 10 cycles -> o_x=0, o_y=0, o_hs=1, o_vs=1, o_active=1, o_pix_stb=0. Release -> o_pix_stb first high at edge 4, then every 4 cycles.
- Horizontal: run one line -> o_hs falls when o_x goes 655->656 and rises at 751->752. o_active falls at 639->640. The line repeats every 3200 cycles.
- Vertical: run one frame -> o_vs low only for o_y=490,491 (6400 cycles). o_active=0 for all o_y>=480.
- Frame pulses: over 3 frames -> exactly one o_animate per frame, with o_x=639, o_y=479 during the pulse. Exactly one o_frame_tick per frame, spaced 1,680,000 cycles apart.
- Wrap: at (799,524) with stb -> next values are (0,0), o_active=1, o_hs=1, o_vs=1.
- Mid-frame reset: assert i_rst_n=0 at o_x=300, o_y=200, asynchronously between edges -> outputs reach reset values before the next edge. After release, the timing matches the first-reset sequence.
